// File: rtl/cla_arb_pkg.sv
// ----------------------------------------------------------------------------
// cla_arb_pkg
// Shared types and constants for the two-requester carry-lookahead adder
// arbiter.
//   W             : operand width, fixed by the attached adder.
//   req_id_t      : requester identifier (0 or 1).
//   pipe_entry_t  : per-stage tag that follows an operation through the adder
//                   latency {valid, id, a_msb, beff_msb}.
//   fifo_entry_t  : buffered response {sum, cout, ovf}.
//   signed_ovf()  : two's-complement overflow from operand and result sign bits.
// ----------------------------------------------------------------------------
package cla_arb_pkg;

    localparam int W = 32;

    typedef logic req_id_t;

    typedef struct packed {
        logic    valid;
        req_id_t id;
        logic    a_msb;
        logic    beff_msb;
    } pipe_entry_t;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } fifo_entry_t;

    // Overflow happens only when both effective operands share a sign and the
    // result sign differs from it.
    function automatic logic signed_ovf(input logic a_msb,
                                        input logic beff_msb,
                                        input logic sum_msb);
        return (a_msb == beff_msb) && (sum_msb != a_msb);
    endfunction

endpackage

// File: rtl/cla_arb_rsp_fifo.sv
// ----------------------------------------------------------------------------
// cla_arb_rsp_fifo
// Per-requester response FIFO. Occupancy is exported so the arbiter can issue
// only when a slot is guaranteed for every outstanding result.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   push       : write push_data (ignored when full and not popping)
//   push_data  : response entry to store
//   pop        : remove the head entry (ignored when empty)
//   head       : head entry, don't-care when empty
//   not_empty  : at least one entry stored
//   count      : number of stored entries, 0..FDEPTH
// ----------------------------------------------------------------------------
module cla_arb_rsp_fifo
    import cla_arb_pkg::*;
#(
    parameter int FDEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  fifo_entry_t               push_data,
    input  logic                      pop,
    output fifo_entry_t               head,
    output logic                      not_empty,
    output logic [$clog2(FDEPTH):0]   count
);

    localparam int AW = $clog2(FDEPTH);
    localparam int CW = AW + 1;

    fifo_entry_t   mem [FDEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          do_push;
    logic          do_pop;

    assign full      = (count == CW'(FDEPTH));
    assign not_empty = (count != '0);
    assign do_pop    = pop && not_empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push   = push && (!full || do_pop);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of its neighbours, independent of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Power-of-two depth: pointers wrap by natural overflow.
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array is deliberately not reset; count gates its use,
    // and leaving it reset-free lets it map onto plain RAM/flops without a
    // reset tree.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

    // The issue credit check must make this impossible; a push here is lost.
    push_never_full : assert property (@(posedge clk) disable iff (rst)
                                       !(push && full && !pop));

endmodule

// File: rtl/cla_add_arbiter.sv
// ----------------------------------------------------------------------------
// cla_add_arbiter
// Round-robin scheduler sharing one pipelined carry-lookahead adder/subtractor
// between two requesters. Each grant registers operands toward the adder and
// tags a tracking pipe of LAT stages; when the tag leaves the pipe the adder
// result is captured into the owner's response FIFO. A requester issues only
// while its buffered plus in-flight results fit in its FIFO, so no result is
// ever dropped.
//
// Parameters: LAT (adder latency, >= 1), FDEPTH (FIFO depth, power of two >= 2)
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   req_valid/ready   : per-requester issue handshake (ready is combinational)
//   req_a, req_b      : operands, requester r at [r*W +: W]
//   req_sub           : 1 = A-B, 0 = A+B
//   add_a/add_b/add_cin : registered operands and carry-in to the adder
//   add_sum/add_cout  : adder result, valid LAT cycles after the handshake
//   rsp_valid/ready   : per-requester response FIFO handshake
//   rsp_sum/cout/ovf  : head-of-FIFO response per requester
// Optional (macro CLA_ARB_PERF_EN):
//   perf_issue        : total grants, wrapping
//   perf_conflict     : cycles with both requesters valid and one refused
//   perf_credit_stall : requester valid but out of FIFO credit
// ----------------------------------------------------------------------------
module cla_add_arbiter
    import cla_arb_pkg::*;
#(
    parameter int LAT    = 6,
    parameter int FDEPTH = 4
) (
    input  logic [0:0]      clk,
    input  logic            rst,
    input  logic [1:0]      req_valid,
    output logic [1:0]      req_ready,
    input  logic [2*W-1:0]  req_a,
    input  logic [2*W-1:0]  req_b,
    input  logic [1:0]      req_sub,
    output logic [W-1:0]    add_a,
    output logic [W-1:0]    add_b,
    output logic            add_cin,
    input  logic [W-1:0]    add_sum,
    input  logic            add_cout,
    output logic [1:0]      rsp_valid,
    input  logic [1:0]      rsp_ready,
    output logic [2*W-1:0]  rsp_sum,
    output logic [1:0]      rsp_cout,
    output logic [1:0]      rsp_ovf
`ifdef CLA_ARB_PERF_EN
    ,
    output logic [31:0]     perf_issue,
    output logic [31:0]     perf_conflict,
    output logic [1:0]      perf_credit_stall
`endif
);

    localparam int CW = $clog2(FDEPTH) + 1;
    localparam logic [CW:0] CREDITS = (CW + 1)'(FDEPTH);

    pipe_entry_t   pipe [LAT];
    logic [CW-1:0] fifo_count [2];
    logic [CW-1:0] inflight   [2];
    logic [1:0]    credit_ok;
    logic [1:0]    eligible;
    logic [1:0]    grant;
    logic          rr_ptr;
    req_id_t       gnt_id;
    logic [W-1:0]  sel_a;
    logic [W-1:0]  sel_b;
    logic          sel_sub;
    pipe_entry_t   tail;
    fifo_entry_t   ret_entry;
    logic [1:0]    push;

    // ------------------------------------------------------------------
    // Credit: buffered results plus results still inside the adder must
    // fit in the FIFO before another operation may be issued.
    // ------------------------------------------------------------------
    // NOTE: every combinational output gets a default before any condition so
    // no path leaves it unassigned, which would infer a latch.
    always_comb begin
        for (int r = 0; r < 2; r++) begin
            inflight[r] = '0;
            for (int s = 0; s < LAT; s++) begin
                if (pipe[s].valid && (pipe[s].id == r[0])) begin
                    inflight[r] = inflight[r] + 1'b1;
                end
            end
            credit_ok[r] = ({1'b0, fifo_count[r]} + {1'b0, inflight[r]}) < CREDITS;
        end
    end

    assign eligible = req_valid & credit_ok;

    // Contention goes to the pointer's requester; a lone eligible requester
    // is served without disturbing the pointer.
    always_comb begin
        grant = 2'b00;
        if (eligible == 2'b11) begin
            grant[rr_ptr] = 1'b1;
        end else begin
            grant = eligible;
        end
    end

    assign req_ready = grant;
    assign gnt_id    = grant[1];
    assign sel_a     = gnt_id ? req_a[2*W-1:W] : req_a[W-1:0];
    assign sel_b     = gnt_id ? req_b[2*W-1:W] : req_b[W-1:0];
    assign sel_sub   = req_sub[gnt_id];

    // ------------------------------------------------------------------
    // Issue registers and the tracking pipe. The pipe never stalls: a
    // result is always accepted because credit was reserved at issue.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            add_a   <= '0;
            add_b   <= '0;
            add_cin <= 1'b0;
            rr_ptr  <= 1'b0;
            for (int s = 0; s < LAT; s++) begin
                pipe[s] <= '0;
            end
        end else begin
            if (|grant) begin
                add_a   <= sel_a;
                add_b   <= sel_b;
                add_cin <= sel_sub;
            end
            if (eligible == 2'b11) begin
                rr_ptr <= ~rr_ptr;
            end
            // Subtraction is a + ~b + 1 inside the adder, so the effective
            // B sign is the inverted raw sign.
            pipe[0] <= '{valid:    |grant,
                         id:       gnt_id,
                         a_msb:    sel_a[W-1],
                         beff_msb: sel_b[W-1] ^ sel_sub};
            for (int s = 1; s < LAT; s++) begin
                pipe[s] <= pipe[s-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Retire: the tag leaves the pipe in the same cycle the adder presents
    // the matching result.
    // ------------------------------------------------------------------
    assign tail      = pipe[LAT-1];
    assign ret_entry = '{sum:  add_sum,
                         cout: add_cout,
                         ovf:  signed_ovf(tail.a_msb, tail.beff_msb, add_sum[W-1])};
    assign push      = {tail.valid && tail.id, tail.valid && !tail.id};

    for (genvar r = 0; r < 2; r++) begin : g_rsp
        fifo_entry_t head;

        cla_arb_rsp_fifo #(
            .FDEPTH (FDEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .push      (push[r]),
            .push_data (ret_entry),
            .pop       (rsp_ready[r]),
            .head      (head),
            .not_empty (rsp_valid[r]),
            .count     (fifo_count[r])
        );

        assign rsp_sum[r*W +: W] = head.sum;
        assign rsp_cout[r]       = head.cout;
        assign rsp_ovf[r]        = head.ovf;
    end

`ifdef CLA_ARB_PERF_EN
    // ------------------------------------------------------------------
    // Performance counters.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_issue    <= '0;
            perf_conflict <= '0;
        end else begin
            if (|grant) begin
                perf_issue <= perf_issue + 32'd1;
            end
            if ((req_valid == 2'b11) && (grant != 2'b11)) begin
                perf_conflict <= perf_conflict + 32'd1;
            end
        end
    end

    assign perf_credit_stall = req_valid & ~credit_ok;
`endif

endmodule

// File: tb/tb_cla_add_arbiter.sv
// ----------------------------------------------------------------------------
// tb_cla_add_arbiter
// Self-checking bench for cla_add_arbiter. An emulated pipelined adder answers
// the DUT's operand ports; a queue-based reference model predicts handshakes,
// response timing and response values from plain arithmetic on the requests.
// ----------------------------------------------------------------------------
module tb_cla_add_arbiter;
    import cla_arb_pkg::*;

    localparam int LAT    = 6;
    localparam int FDEPTH = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [1:0]     req_valid, req_ready, req_sub;
    logic [2*W-1:0] req_a, req_b;
    logic [W-1:0]   add_a, add_b, add_sum;
    logic           add_cin, add_cout;
    logic [1:0]     rsp_valid, rsp_ready, rsp_cout, rsp_ovf;
    logic [2*W-1:0] rsp_sum;
`ifdef CLA_ARB_PERF_EN
    logic [31:0]    perf_issue, perf_conflict;
    logic [1:0]     perf_credit_stall;
`endif

    always #5 clk = ~clk;

    cla_add_arbiter #(.LAT(LAT), .FDEPTH(FDEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_sub   (req_sub),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_sum   (add_sum),
        .add_cout  (add_cout),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .rsp_ovf   (rsp_ovf)
`ifdef CLA_ARB_PERF_EN
        ,
        .perf_issue        (perf_issue),
        .perf_conflict     (perf_conflict),
        .perf_credit_stall (perf_credit_stall)
`endif
    );

    // ------------------------------------------------------------------
    // Adder emulation: the result for operands registered at the handshake
    // edge is presented LAT cycles after the handshake cycle.
    // ------------------------------------------------------------------
    logic [W-1:0] ha [LAT] = '{default: '0};
    logic [W-1:0] hb [LAT] = '{default: '0};
    logic         hc [LAT] = '{default: 1'b0};

    always @(posedge clk) begin
        logic [W-1:0] beff;
        #1;
        for (int i = LAT - 1; i > 0; i--) begin
            ha[i] = ha[i-1];
            hb[i] = hb[i-1];
            hc[i] = hc[i-1];
        end
        ha[0] = add_a;
        hb[0] = add_b;
        hc[0] = add_cin;
        beff  = hc[LAT-1] ? ~hb[LAT-1] : hb[LAT-1];
        {add_cout, add_sum} = {1'b0, ha[LAT-1]} + {1'b0, beff} + {{W{1'b0}}, hc[LAT-1]};
    end

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic [31:0]  due;
    } exp_t;

    exp_t         expq [2][$];
    logic         m_ptr;
    logic [W-1:0] m_add_a, m_add_b;
    logic         m_add_cin;
    int           cyc;
    int           n_cmp = 0;
    int           n_bad = 0;

    // Observations of the DUT used by the directed literal checks.
    logic [1:0]   obs_ready;
    logic [1:0]   pop_seen;
    int           hs_cyc  [2];
    int           pop_cyc [2];
    int           pop_cnt [2];
    int           gnt_cnt [2];
    int           glog [$];
    logic [W-1:0] got_sum  [2];
    logic         got_cout [2];
    logic         got_ovf  [2];

    // Result of a +/- b using signed and unsigned integer arithmetic.
    function automatic exp_t model_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                      input logic sub, input int due);
        exp_t       e;
        longint     sa, sb, sres;
        logic [W:0] ures;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (sub) begin
            sres   = sa - sb;
            ures   = {1'b0, a} - {1'b0, b};
            e.sum  = ures[W-1:0];
            e.cout = (a >= b);
        end else begin
            sres   = sa + sb;
            ures   = {1'b0, a} + {1'b0, b};
            e.sum  = ures[W-1:0];
            e.cout = ures[W];
        end
        e.ovf = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
        e.due = 32'(due);
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got 0x%0h, required 0x%0h", name, cyc, act, exp);
        end
    endtask

    // One clock cycle: inputs are already applied; compare every output with
    // the model, advance the model, then move to the next falling edge.
    task automatic tick();
        logic [1:0] el, gnt, ev;
        exp_t       e;
        #1;
        for (int r = 0; r < 2; r++) begin
            el[r] = req_valid[r] && (expq[r].size() < FDEPTH);
            ev[r] = (expq[r].size() > 0) && (int'(expq[r][0].due) <= cyc);
        end
        gnt = (el == 2'b11) ? (m_ptr ? 2'b10 : 2'b01) : el;

        check("req_ready", req_ready, gnt);
        check("rsp_valid", rsp_valid, ev);
        check("add_a", add_a, m_add_a);
        check("add_b", add_b, m_add_b);
        check("add_cin", add_cin, m_add_cin);
        for (int r = 0; r < 2; r++) begin
            if (ev[r]) begin
                e = expq[r][0];
                check($sformatf("rsp_sum[%0d]", r), rsp_sum[r*W +: W], e.sum);
                check($sformatf("rsp_cout[%0d]", r), rsp_cout[r], e.cout);
                check($sformatf("rsp_ovf[%0d]", r), rsp_ovf[r], e.ovf);
            end
        end

        obs_ready = req_ready;
        for (int r = 0; r < 2; r++) begin
            if (req_valid[r] && req_ready[r] && !rst) begin
                hs_cyc[r] = cyc;
                gnt_cnt[r]++;
                glog.push_back(r);
            end
            if (rsp_valid[r] && rsp_ready[r] && !rst) begin
                pop_seen[r] = 1'b1;
                pop_cyc[r]  = cyc;
                pop_cnt[r]++;
                got_sum[r]  = rsp_sum[r*W +: W];
                got_cout[r] = rsp_cout[r];
                got_ovf[r]  = rsp_ovf[r];
            end
        end

        if (rst) begin
            expq[0].delete();
            expq[1].delete();
            m_ptr     = 1'b0;
            m_add_a   = '0;
            m_add_b   = '0;
            m_add_cin = 1'b0;
        end else begin
            for (int r = 0; r < 2; r++) begin
                if (ev[r] && rsp_ready[r]) void'(expq[r].pop_front());
                if (gnt[r]) begin
                    expq[r].push_back(model_op(req_a[r*W +: W], req_b[r*W +: W],
                                               req_sub[r], cyc + 1 + LAT));
                    m_add_a   = req_a[r*W +: W];
                    m_add_b   = req_b[r*W +: W];
                    m_add_cin = req_sub[r];
                end
            end
            if (el == 2'b11) m_ptr = ~m_ptr;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic wait_pop(input int r, input int budget);
        int n;
        n = 0;
        while (!pop_seen[r] && n < budget) begin
            tick();
            n++;
        end
        check($sformatf("response %0d arrives within budget", r), pop_seen[r], 1);
    endtask

    function automatic logic [W-1:0] rand_op();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return W'($urandom);
        endcase
    endfunction

    task automatic rand_operands();
        req_a   = {rand_op(), rand_op()};
        req_b   = {rand_op(), rand_op()};
        req_sub = 2'($urandom_range(0, 3));
    endtask

`ifdef CLA_ARB_PERF_EN
    logic [31:0] perf_issue_0, perf_conflict_0;
`endif

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_sub   = '0;
        rsp_ready = '0;
        m_ptr     = 1'b0;
        m_add_a   = '0;
        m_add_b   = '0;
        m_add_cin = 1'b0;
        cyc       = 0;
        pop_seen  = '0;
        obs_ready = '0;
        for (int r = 0; r < 2; r++) begin
            hs_cyc[r]  = 0;
            pop_cyc[r] = 0;
            pop_cnt[r] = 0;
            gnt_cnt[r] = 0;
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset req_ready", req_ready, 2'b00);
        check("reset rsp_valid", rsp_valid, 2'b00);
        check("reset add_a", add_a, '0);
        check("reset add_b", add_b, '0);
        check("reset add_cin", add_cin, 1'b0);

        // Requester 0: 5 + 3.
        rsp_ready = 2'b11;
        req_valid = 2'b01;
        req_a     = {32'h0, 32'h0000_0005};
        req_b     = {32'h0, 32'h0000_0003};
        req_sub   = 2'b00;
        pop_seen  = '0;
        tick();
        check("add req_ready[0] same cycle", obs_ready[0], 1'b1);
        req_valid = 2'b00;
        wait_pop(0, 40);
        check("add latency", pop_cyc[0] - hs_cyc[0], 1 + LAT);
        check("add sum", got_sum[0], 32'h0000_0008);
        check("add cout", got_cout[0], 1'b0);
        check("add ovf", got_ovf[0], 1'b0);

        // Requester 1: 0 - 1.
        req_valid = 2'b10;
        req_a     = {32'h0000_0000, 32'h0};
        req_b     = {32'h0000_0001, 32'h0};
        req_sub   = 2'b10;
        pop_seen  = '0;
        tick();
        req_valid = 2'b00;
        wait_pop(1, 40);
        check("0-1 sum", got_sum[1], 32'hFFFF_FFFF);
        check("0-1 cout", got_cout[1], 1'b0);
        check("0-1 ovf", got_ovf[1], 1'b0);

        // Requester 1: 0x8000_0000 - 1 overflows.
        req_valid = 2'b10;
        req_a     = {32'h8000_0000, 32'h0};
        pop_seen  = '0;
        tick();
        req_valid = 2'b00;
        wait_pop(1, 40);
        check("min-1 sum", got_sum[1], 32'h7FFF_FFFF);
        check("min-1 cout", got_cout[1], 1'b1);
        check("min-1 ovf", got_ovf[1], 1'b1);

        // Both requesters valid for 20 cycles: strict alternation from 0.
        repeat (4) tick();
        glog.delete();
`ifdef CLA_ARB_PERF_EN
        perf_issue_0    = perf_issue;
        perf_conflict_0 = perf_conflict;
`endif
        req_valid = 2'b11;
        for (int i = 0; i < 20; i++) begin
            rand_operands();
            tick();
        end
        req_valid = 2'b00;
        check("contention grant count", glog.size(), 20);
        for (int i = 0; i < glog.size() && i < 20; i++) begin
            check($sformatf("contention grant %0d", i), glog[i], i % 2);
        end
`ifdef CLA_ARB_PERF_EN
        check("perf_issue delta", perf_issue - perf_issue_0, 32'd20);
        check("perf_conflict delta", perf_conflict - perf_conflict_0, 32'd20);
`endif
        repeat (2 * LAT) tick();

        // Back-pressure on requester 0.
        gnt_cnt[0] = 0;
        pop_cnt[0] = 0;
        rsp_ready  = 2'b00;
        req_valid  = 2'b01;
        for (int i = 0; i < 16; i++) begin
            rand_operands();
            tick();
        end
        check("credit-limited grants", gnt_cnt[0], FDEPTH);
        check("req_ready[0] held low when full", obs_ready[0], 1'b0);
`ifdef CLA_ARB_PERF_EN
        check("perf_credit_stall[0]", perf_credit_stall[0], 1'b1);
`endif
        rsp_ready = 2'b01;
        tick();
        rsp_ready = 2'b00;
        for (int i = 0; i < 10; i++) begin
            rand_operands();
            tick();
        end
        check("one pop frees one grant", gnt_cnt[0], FDEPTH + 1);
        req_valid = 2'b00;
        rsp_ready = 2'b01;
        repeat (3 * LAT) tick();
        check("no result lost", pop_cnt[0], FDEPTH + 1);

        // Reset with two buffered results and three in flight.
        rsp_ready = 2'b00;
        req_valid = 2'b01;
        rand_operands();
        tick();
        req_valid = 2'b10;
        tick();
        req_valid = 2'b00;
        repeat (LAT + 2) tick();
        check("buffered before reset", rsp_valid, 2'b11);
        req_valid = 2'b01;
        rand_operands();
        tick();
        req_valid = 2'b10;
        tick();
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("rsp_valid after reset", rsp_valid, 2'b00);
        repeat (2 * LAT) tick();
        check("no late pushes after reset", rsp_valid, 2'b00);

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            req_valid = 2'($urandom_range(0, 3));
            rsp_ready = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
            rand_operands();
            tick();
        end
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        repeat (3 * LAT) tick();
        check("drained", rsp_valid, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
